// File: rtl/audio_rate_gen.sv
// Fractional sample-rate tick generator with optional SOF-period measurement
// in 10.14 format (enabled by defining AUDIO_RATE_MEAS_EN).
module audio_rate_gen #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] inc_val,
    input  logic             inc_load,
    output logic             tick,
    input  logic             sof,
    output logic [23:0]      meas_val,
    output logic             meas_stb
);

    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum_s;

    // Phase accumulation; the load cycle still accumulates with the old increment.
    always_comb begin
        sum_s  = {1'b0, acc_q} + {1'b0, inc_q};
        inc_d  = inc_q;
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (inc_load) begin
            inc_d = inc_val;
        end else begin
            inc_d = inc_q;
        end
        if (en) begin
            acc_d  = sum_s[ACC_W-1:0];
            tick_d = sum_s[ACC_W];
        end else begin
            acc_d  = {ACC_W{1'b0}};
            tick_d = 1'b0;
        end
    end

    // Tick generator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q  <= {ACC_W{1'b0}};
            acc_q  <= {ACC_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            inc_q  <= inc_d;
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef AUDIO_RATE_MEAS_EN
    logic [9:0]  tcnt_q, tcnt_d;
    logic [23:0] snap_prev_q, snap_prev_d;
    logic        first_q, first_d;
    logic [23:0] meas_val_q, meas_val_d;
    logic        meas_stb_q, meas_stb_d;
    logic [23:0] snap_s;

    // Snapshot uses post-update values so a carry on the SOF cycle closes into this frame.
    always_comb begin
        tcnt_d      = tcnt_q;
        snap_prev_d = snap_prev_q;
        first_d     = first_q;
        meas_val_d  = meas_val_q;
        meas_stb_d  = 1'b0;
        if (en && sum_s[ACC_W]) begin
            tcnt_d = tcnt_q + 10'd1;
        end else begin
            tcnt_d = tcnt_q;
        end
        snap_s = {tcnt_d, acc_d[ACC_W-1 -: 14]};
        if (sof) begin
            if (!first_q) begin
                meas_val_d = snap_s - snap_prev_q;
                meas_stb_d = 1'b1;
            end else begin
                meas_stb_d = 1'b0;
            end
            snap_prev_d = snap_s;
            first_d     = 1'b0;
        end else begin
            snap_prev_d = snap_prev_q;
        end
        // While disabled the phase is meaningless, so the next SOF must re-prime.
        if (!en) begin
            first_d = 1'b1;
        end else begin
            first_d = first_d;
        end
    end

    // Measurement state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q      <= 10'd0;
            snap_prev_q <= 24'd0;
            first_q     <= 1'b1;
            meas_val_q  <= 24'd0;
            meas_stb_q  <= 1'b0;
        end else begin
            tcnt_q      <= tcnt_d;
            snap_prev_q <= snap_prev_d;
            first_q     <= first_d;
            meas_val_q  <= meas_val_d;
            meas_stb_q  <= meas_stb_d;
        end
    end

    assign meas_val = meas_val_q;
    assign meas_stb = meas_stb_q;
`else
    logic unused_sof_s;

    assign unused_sof_s = sof;
    assign meas_val     = 24'd0;
    assign meas_stb     = 1'b0;
`endif

endmodule

// File: tb/tb_audio_rate_gen.sv
// Self-checking bench for audio_rate_gen: directed scenarios plus random traffic
// checked every cycle against a behavioural phase/tick-count model.
module tb_audio_rate_gen;

    localparam int ACC_W = 24;
    localparam longint MODW = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [ACC_W-1:0] inc_val;
    logic             inc_load;
    logic             tick;
    logic             sof;
    logic [23:0]      meas_val;
    logic             meas_stb;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (total tick count kept unbounded)
    longint m_inc, m_acc;
    int     m_ticks, m_prev_ticks;
    longint m_prev_frac;
    bit     m_first, m_tick, m_stb;
    logic [23:0] m_val;

    audio_rate_gen #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .inc_val(inc_val), .inc_load(inc_load),
        .tick(tick), .sof(sof), .meas_val(meas_val), .meas_stb(meas_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inc = 0; m_acc = 0; m_ticks = 0; m_prev_ticks = 0; m_prev_frac = 0;
        m_first = 1'b1; m_tick = 1'b0; m_stb = 1'b0; m_val = 24'd0;
    endtask

    task automatic model_step();
        longint sum, frac, diff;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (en) begin
                sum = m_acc + m_inc;
                m_tick = (sum >= MODW);
                m_acc = sum % MODW;
                if (m_tick) m_ticks++;
            end else begin
                m_acc = 0;
                m_tick = 1'b0;
            end
            if (inc_load) m_inc = longint'(inc_val);
            m_stb = 1'b0;
`ifdef AUDIO_RATE_MEAS_EN
            if (sof) begin
                frac = m_acc >> (ACC_W - 14);
                if (!m_first) begin
                    diff = longint'(m_ticks - m_prev_ticks) * 16384 + frac - m_prev_frac;
                    m_val = 24'(diff);
                    m_stb = 1'b1;
                end
                m_prev_ticks = m_ticks;
                m_prev_frac = frac;
                m_first = 1'b0;
            end
            if (!en) m_first = 1'b1;
`endif
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("meas_stb", {31'd0, meas_stb}, {31'd0, m_stb});
        chk("meas_val", {8'd0, meas_val}, {8'd0, m_val});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            inc_load = 1'b0; sof = 1'b0;
            cyc();
        end
    endtask

    task automatic load(input logic [ACC_W-1:0] v);
        inc_val = v; inc_load = 1'b1;
        cyc();
        inc_load = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        cyc();
        sof = 1'b0;
    endtask

    initial begin
        int cnt, stbs;
        logic [31:0] r;
        logic [23:0] v1;
        model_reset();
        rst_n = 1'b0; en = 1'b0; inc_val = '0; inc_load = 1'b0; sof = 1'b0;
        #2;
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_meas_val", {8'd0, meas_val}, 32'd0);
        chk("reset_meas_stb", {31'd0, meas_stb}, 32'd0);
        run(3);
        rst_n = 1'b1;

        // Half-rate increment: tick every second cycle
        en = 1'b1;
        load(24'h800000);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            if (tick) cnt++;
        end
        chk("half_rate_count", cnt, 32'd10);

        // 48 kHz nominal from 24 MHz
        load(24'h008312);
        cnt = 0;
        for (int i = 0; i < 24000; i++) begin
            run(1);
            if (tick) cnt++;
        end
        chk("rate_48k_in_range", {31'd0, (cnt == 47 || cnt == 48)}, 32'd1);

        // Mid-run reload to quarter rate
        load(24'h400000);
        run(8);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (tick) cnt++;
        end
        chk("quarter_rate_count", cnt, 32'd10);

        // SOF every 1000 cycles at quarter rate
        stbs = 0;
        for (int f = 0; f < 4; f++) begin
            pulse_sof();
            if (meas_stb) begin
                stbs++;
                chk("meas_250", {8'd0, meas_val}, 32'h003E8000);
            end
            run(999);
        end
`ifdef AUDIO_RATE_MEAS_EN
        chk("strobe_count", stbs, 32'd3);
`else
        chk("strobe_count", stbs, 32'd0);
`endif

        // SOF coinciding with a carry, then two uneven frames summing to 2000 cycles
        for (int i = 0; i < 8 && !((m_acc + m_inc) >= MODW); i++) run(1);
        pulse_sof();
        chk("sof_on_carry_tick", {31'd0, tick}, 32'd1);
        run(1002);
        pulse_sof();
        v1 = meas_val;
        run(996);
        pulse_sof();
`ifdef AUDIO_RATE_MEAS_EN
        chk("two_frame_sum", {8'd0, 24'(v1 + meas_val)}, 32'h007D0000);
`endif

        // Disable for 100 cycles, then re-prime
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            run(1);
            if (tick) cnt++;
        end
        chk("disabled_no_ticks", cnt, 32'd0);
        en = 1'b1;
        run(37);
        pulse_sof();
        chk("reprime_no_stb", {31'd0, meas_stb}, 32'd0);
        run(999);
        pulse_sof();
`ifdef AUDIO_RATE_MEAS_EN
        chk("after_reprime_val", {8'd0, meas_val}, 32'h003E8000);
`endif

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199) == 0) en = ~en;
            inc_load = ($urandom_range(299) == 0);
            r = $urandom;
            inc_val = r[ACC_W-1:0];
            sof = ($urandom_range(249) == 0);
            cyc();
        end
        inc_load = 1'b0; sof = 1'b0;

        // Reset asserted mid-frame with a tick in flight
        en = 1'b1;
        load(24'h800000);
        pulse_sof();
        run(500);
        if (!tick) run(1);
        pulse_sof();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tick", {31'd0, tick}, 32'd0);
        chk("async_reset_meas_val", {8'd0, meas_val}, 32'd0);
        chk("async_reset_meas_stb", {31'd0, meas_stb}, 32'd0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        load(24'h400000);
        pulse_sof();
        chk("post_reset_prime", {31'd0, meas_stb}, 32'd0);
        run(999);
        pulse_sof();
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
